// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a small receive buffer.
// Latency: a byte reaches data/data_ready one clock after its stop-bit sample edge.
// Backpressure: none toward the line; a byte arriving to a full buffer with no pop is dropped and overflow latches.
//
// Ports: clk, rst_n (async active-low); rx (async serial, idle high, LSB first);
//        data/data_ready (buffer head, valid while data_ready=1); read_en pops the head;
//        count (bytes buffered); overflow (sticky, cleared by clear_errors);
//        framing_error (one-cycle pulse when a stop bit is sampled low).
// Build option: define UART_RX_BUFFER_FIFO_EN for a 2^FIFO_DEPTH_BITWIDTH-byte circular
//        FIFO; without it the buffer is one holding register and FIFO_DEPTH_BITWIDTH
//        only sets the width of count.
`timescale 1ns/1ps

module uart_rx_buffer #(
  parameter int CLK_FREQ            = 20_250_000,
  parameter int BAUD_RATE           = 115_200,
  parameter int FIFO_DEPTH_BITWIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [7:0]                   data,
  output logic                         data_ready,
  input  logic                         read_en,
  output logic [FIFO_DEPTH_BITWIDTH:0] count,
  output logic                         overflow,
  output logic                         framing_error,
  input  logic                         clear_errors
);

  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = BIT_TIME / 2;
  localparam int CNT_W    = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_TIME - 1);
  // The cycle in which IDLE sees the falling edge is the first of the
  // BIT_TIME/2 clocks to mid-start-bit, so START counts one fewer. With
  // BIT_TIME=1 the edge sample already is mid-bit and START is skipped.
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync_meta_q, sync_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             framing_error_q, framing_error_d;
  logic             overflow_q, overflow_d;
  logic             cnt_zero;
  logic             push_req, frame_err;
  logic             push_ok, pop, ovf_event;

  assign cnt_zero = (cnt_q == '0);

  // State register (also holds the receive datapath).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      sync_meta_q     <= 1'b1;
      rx_s_q          <= 1'b1;
      framing_error_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      sync_meta_q     <= sync_meta_d;
      rx_s_q          <= rx_s_d;
      framing_error_q <= framing_error_d;
      overflow_q      <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    sync_meta_d = rx;
    rx_s_d      = sync_meta_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          if (HALF_BIT == 0) begin
            state_d   = ST_DATA;
            cnt_d     = BIT_RELOAD;
            bit_idx_d = '0;
          end else begin
            state_d = ST_START;
            cnt_d   = HALF_RELOAD;
          end
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            cnt_d     = BIT_RELOAD;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;  // line went back high: glitch, not a start bit
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          shift_d   = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          cnt_d     = BIT_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_zero) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs of the receiver FSM.
  always_comb begin
    push_req  = 1'b0;
    frame_err = 1'b0;
    if (state_q == ST_STOP && cnt_zero) begin
      push_req  = rx_s_q;
      frame_err = !rx_s_q;
    end
  end

  always_comb begin
    framing_error_d = frame_err;
    // An overflow in the same cycle as clear_errors must survive.
    overflow_d = ovf_event ? 1'b1 : (clear_errors ? 1'b0 : overflow_q);
  end

  assign framing_error = framing_error_q;
  assign overflow      = overflow_q;

`ifdef UART_RX_BUFFER_FIFO_EN
  localparam int DEPTH = 1 << FIFO_DEPTH_BITWIDTH;
  localparam int PW    = FIFO_DEPTH_BITWIDTH;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          fifo_empty, fifo_full;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (PW+1)'(DEPTH));
    pop        = read_en && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok    = push_req && (!fifo_full || pop);
    ovf_event  = push_req && fifo_full && !pop;
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: it is only visible through the valid head.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_ready = !fifo_empty;
  assign data       = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count      = count_q;
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  always_comb begin
    pop       = read_en && full_q;
    push_ok   = push_req && (!full_q || pop);
    ovf_event = push_req && full_q && !pop;
    hold_d    = push_ok ? shift_q : hold_q;
    full_d    = push_ok ? 1'b1 : (pop ? 1'b0 : full_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign data_ready = full_q;
  assign data       = full_q ? hold_q : 8'h00;
  assign count      = {{FIFO_DEPTH_BITWIDTH{1'b0}}, full_q};
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: self-checking bench for uart_rx_buffer.
// Two instances: BIT_TIME=10 (main checks, random bytes) and BIT_TIME=1.
// Expected buffer contents come from a byte queue capped at the build's depth.
`timescale 1ns/1ps

module tb_uart_rx_buffer;

  localparam int CLK_HZ = 20_250_000;
  localparam int BT0    = 10;
  localparam int BT1    = 1;
`ifdef UART_RX_BUFFER_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n = 1'b0, rst1_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       read_en0 = 1'b0, read_en1 = 1'b0;
  logic       clear0 = 1'b0, clear1 = 1'b0;
  logic [7:0] data0, data1;
  logic       dr0, dr1, ovf0, ovf1, ferr0, ferr1;
  logic [3:0] count0, count1;

  uart_rx_buffer #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(CLK_HZ / BT0), .FIFO_DEPTH_BITWIDTH(3)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .rx(rx0), .data(data0), .data_ready(dr0), .read_en(read_en0),
    .count(count0), .overflow(ovf0), .framing_error(ferr0), .clear_errors(clear0));

  uart_rx_buffer #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(CLK_HZ / BT1), .FIFO_DEPTH_BITWIDTH(3)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .rx(rx1), .data(data1), .data_ready(dr1), .read_en(read_en1),
    .count(count1), .overflow(ovf1), .framing_error(ferr1), .clear_errors(clear1));

  int vectors = 0;
  int miscompares = 0;
  int ferr_cnt0 = 0, ferr_cnt1 = 0, ferr_long = 0;
  logic ferr_prev0 = 1'b0;

  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;
  int         lat = 0;

  always @(negedge clk) begin
    if (ferr0) begin
      ferr_cnt0++;
      if (ferr_prev0) ferr_long++;
    end
    ferr_prev0 = ferr0;
    if (ferr1) ferr_cnt1++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  // Drive one 8N1 frame; stop_low holds the stop bit low for that many bit
  // times; abort_bits >= 0 stops driving after that many data bits.
  task automatic send_frame(input bit sel, input logic [7:0] b, input int stop_low, input int abort_bits);
    int bt;
    bt = sel ? BT1 : BT0;
    set_rx(sel, 1'b0);
    tick(bt);
    for (int i = 0; i < 8; i++) begin
      if (abort_bits == i) return;
      set_rx(sel, b[i]);
      tick(bt);
    end
    if (stop_low > 0) begin
      set_rx(sel, 1'b0);
      tick(bt * stop_low);
    end
    set_rx(sel, 1'b1);
    tick(bt);
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    check_eq($sformatf("%s.count", tag), 32'(count0), exp_q.size());
    check_eq($sformatf("%s.data_ready", tag), 32'(dr0), (exp_q.size() != 0) ? 1 : 0);
    check_eq($sformatf("%s.data", tag), 32'(data0), (exp_q.size() != 0) ? 32'(exp_q[0]) : 0);
    check_eq($sformatf("%s.overflow", tag), 32'(ovf0), 32'(exp_ovf));
  endtask

  // read_en held for n consecutive cycles; reads on an empty buffer must do nothing.
  task automatic read0(input string tag, input int n);
    read_en0 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() != 0) begin
        check_eq($sformatf("%s.rd%0d", tag, i), 32'(data0), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        check_eq($sformatf("%s.rd%0d_empty", tag, i), 32'(dr0), 0);
      end
      tick(1);
    end
    read_en0 = 1'b0;
    check_eq($sformatf("%s.count_after", tag), 32'(count0), exp_q.size());
  endtask

  task automatic clear_pulse();
    clear0 = 1'b1;
    tick(1);
    clear0 = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Send a byte and strobe read_en (use_clear=0) or clear_errors (use_clear=1)
  // for exactly the clock edge on which the stop bit is accepted.
  task automatic send_with_strobe(input string tag, input logic [7:0] b, input bit use_clear);
    bit popped;
    popped = 1'b0;
    fork
      send_frame(1'b0, b, 0, -1);
      begin
        tick(lat - 1);
        if (use_clear) clear0 = 1'b1;
        else begin
          read_en0 = 1'b1;
          if (exp_q.size() != 0) begin
            check_eq($sformatf("%s.head_before_pop", tag), 32'(data0), 32'(exp_q[0]));
            popped = 1'b1;
          end else begin
            check_eq($sformatf("%s.empty_before_pop", tag), 32'(dr0), 0);
          end
        end
        tick(1);
        clear0   = 1'b0;
        read_en0 = 1'b0;
      end
    join
    if (popped) void'(exp_q.pop_front());
    if (use_clear) begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(b);
    end else begin
      model_push(b);
    end
    check_state(tag);
  endtask

  initial begin
    logic [7:0] b;
    int nr;

    // Reset state, checked while reset is held.
    tick(3);
    check_state("reset");
    check_eq("reset.framing_error", 32'(ferr0), 0);
    check_eq("reset1.count", 32'(count1), 0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    tick(5);

    // Single byte into an empty buffer; also measures the stop-accept edge.
    fork
      send_frame(1'b0, 8'hAA, 0, -1);
      begin
        lat = 0;
        for (int c = 1; c <= 300; c++) begin
          tick(1);
          if (dr0 === 1'b1) begin
            lat = c;
            break;
          end
        end
      end
    join
    check_eq("aa.arrival_in_stop_bit", ((lat >= 9 * BT0 + 2) && (lat <= 10 * BT0 + 2)) ? 1 : 0, 1);
    if (lat < 2) lat = 9 * BT0 + 8;
    model_push(8'hAA);
    check_state("aa");
    check_eq("aa.no_framing_error", ferr_cnt0, 0);
    read0("aa_rd", 1);

    // Back-to-back frames, then three read cycles.
    send_frame(1'b0, 8'h55, 0, -1); model_push(8'h55);
    send_frame(1'b0, 8'h0F, 0, -1); model_push(8'h0F);
    send_frame(1'b0, 8'hF0, 0, -1); model_push(8'hF0);
    check_state("b2b");
    read0("b2b_rd", 3);
    check_state("b2b_drained");
    clear_pulse();
    check_eq("b2b.overflow_cleared", 32'(ovf0), 0);

    // Stop bit held low: one framing pulse, byte dropped, then recovery.
    send_frame(1'b0, 8'h3C, 20, -1);
    tick(2 * BT0);
    check_eq("brk.framing_pulses", ferr_cnt0, 1);
    check_eq("brk.pulse_width_1", ferr_long, 0);
    check_state("brk");
    send_frame(1'b0, 8'h81, 0, -1);
    model_push(8'h81);
    check_state("after_brk");
    read0("after_brk_rd", 1);

    // Fill past capacity.
    for (int i = 1; i <= 9; i++) begin
      send_frame(1'b0, 8'(i), 0, -1);
      model_push(8'(i));
    end
    check_state("fill9");
    clear_pulse();
    check_state("fill9_cleared");

    // Overflow coinciding with clear_errors, then push+pop while full.
    send_with_strobe("clr_vs_ovf", 8'h0A, 1'b1);
    clear_pulse();
    check_state("clr_vs_ovf_cleared");
    send_with_strobe("push_pop_full", 8'h0B, 1'b0);
    read0("drain_full", DEPTH + 1);
    check_state("drained");

    // Push+pop while empty: only the push takes effect.
    send_with_strobe("push_pop_empty", 8'h6E, 1'b0);
    read0("pp_empty_rd", 1);

    // Short glitch on the line.
    rx0 = 1'b0;
    tick(3);
    rx0 = 1'b1;
    tick(3 * BT0);
    check_state("glitch");
    check_eq("glitch.no_framing_error", ferr_cnt0, 1);

    // Reset in the middle of a frame, then a clean frame.
    send_frame(1'b0, 8'h77, 0, 4);
    rst0_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(2);
    check_state("rst_mid");
    rx0 = 1'b1;
    rst0_n = 1'b1;
    tick(3 * BT0);
    check_state("post_rst");
    send_frame(1'b0, 8'h12, 0, -1);
    model_push(8'h12);
    check_state("after_rst_12");
    read0("after_rst_rd", 1);

    // Random bytes with random read bursts and occasional clears.
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      send_frame(1'b0, b, 0, -1);
      model_push(b);
      check_state($sformatf("rnd%0d", k));
      nr = $urandom_range(0, 2);
      for (int j = 0; j < nr; j++) read0($sformatf("rnd%0d_rd%0d", k, j), 1);
      if ($urandom_range(0, 3) == 0) clear_pulse();
      check_state($sformatf("rnd%0d_post", k));
    end
    check_eq("total_framing_pulses", ferr_cnt0, 1);

    // One-clock bit time.
    send_frame(1'b1, 8'hA5, 0, -1);
    tick(3);
    check_eq("bt1.data", 32'(data1), 32'hA5);
    check_eq("bt1.data_ready", 32'(dr1), 1);
    check_eq("bt1.count", 32'(count1), 1);
    read_en1 = 1'b1;
    tick(1);
    read_en1 = 1'b0;
    check_eq("bt1.drained", 32'(dr1), 0);
    b = 8'($urandom);
    send_frame(1'b1, b, 0, -1);
    tick(3);
    check_eq("bt1.rnd_data", 32'(data1), 32'(b));
    send_frame(1'b1, ~b, 0, -1);
    tick(3);
    check_eq("bt1.head_kept", 32'(data1), 32'(b));
    check_eq("bt1.count2", 32'(count1), (DEPTH > 1) ? 2 : 1);
    check_eq("bt1.overflow", 32'(ovf1), (DEPTH == 1) ? 1 : 0);
    check_eq("bt1.no_framing_error", ferr_cnt1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
